imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the single-cycle core's instruction memory. It receives a framed byte stream on a valid/ready interface and packs bytes into 32-bit little-endian words. Each word is written into instruction memory at consecutive word addresses. The core is held stopped until a complete frame with a correct checksum has been written.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity is 2**ADDR_W words.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: byte available on `in_data`.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader can accept a byte. A byte transfers on a cycle with `in_valid & in_ready`.
- `start`  in  1: re-arm request, honoured only in DONE or ERROR.
- `we`  out  1: one-cycle instruction-memory write strobe.
- `waddr`  out  ADDR_W: word address for the write.
- `wdata`  out  32: word to write.
- `core_run`  out  1: core enable; 0 holds the processor (PC at 0).
- `busy`  out  1: a frame is in progress, i.e. any state other than HDR0, DONE or ERROR.
- `error`  out  1: frame rejected.
- `words_loaded`  out  ADDR_W+1: count of words written in the current frame.

## Operation
- Frame format: count lo, count hi, count×4 payload bytes, checksum.
  - Count is a 16-bit word count, little-endian.
  - Payload is little-endian words: the first byte of each group of 4 goes to `wdata[7:0]`.
  - Checksum is the XOR of all payload bytes.
- States: HDR0 → HDR1 → DATA → CSUM → DONE | ERROR.
- HDR0: on the accepted byte, latch count[7:0] and go to HDR1.
- HDR1: on the accepted byte, latch count[15:8].
  - count > 2**ADDR_W → ERROR.
  - count == 0 → CSUM.
  - otherwise → DATA.
- DATA:
  - Keep a 2-bit byte index, a running XOR, and a word index starting at 0.
  - On the 4th byte of a word, issue the write.
  - After the write of word count-1, go to CSUM.
- CSUM: the accepted byte is compared with the running XOR.
  - Equal → DONE.
  - Unequal → ERROR.
- DONE: `core_run`=1, `in_ready`=0. Stays until `start` or `rst`.
- ERROR: `error`=1, `core_run`=0, `in_ready`=0. Stays until `start` or `rst`.
  - Words already written are not retracted.
- `start` in DONE/ERROR:
  - Go to HDR0 and drop `core_run`/`error`.
  - Clear the XOR, the indices and `words_loaded`.
  - `start` in any other state is ignored.
- `in_ready` is a combinational decode of the state: 1 in HDR0, HDR1, DATA and CSUM.
- The loader never drops or duplicates a byte. Idle gaps on `in_valid` are legal in every state.

## Timing
- Reset values:
  - State HDR0, so `in_ready`=1.
  - `we`=0, `waddr`=0, `wdata`=0.
  - `core_run`=0, `busy`=0, `error`=0, `words_loaded`=0.
- Write latency: `we`, `waddr` and `wdata` are registered.
  - They are valid for exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - `words_loaded` increments in that same cycle.
- Final word: its `we` pulse coincides with the first cycle of CSUM. The checksum byte may be accepted in that same cycle.
- `core_run` or `error` rises the cycle after the checksum byte is accepted.
- Oversize count: `error` rises the cycle after the second header byte is accepted. No `we` is issued.
- `core_run`/`error` fall the cycle after `start` is sampled.
- Throughput: one byte per cycle, so one word write per 4 cycles with no stalls.
- `rst` mid-frame:
  - The partial word is discarded and every output returns to its reset value immediately.
  - Memory contents already written are left unchanged.
- `waddr` never exceeds 2**ADDR_W-1; the count check guarantees this.

## Structure
- Package `imem_loader_pkg`:
  - State enum (HDR0, HDR1, DATA, CSUM, DONE, ERROR).
  - Frame constants: header length 2, bytes per word 4.
- Sub-module `byte_packer`:
  - Ports: byte-valid in, byte in, 32-bit word out, word-done pulse out.
  - Contains the 2-bit byte index and the shift register.
  - Cleared by the FSM on frame start.
- The FSM, count compare, XOR and output registers live in `imem_loader`.

## Test plan
- Nominal load, no stalls:
  - Stimulus: 02 00 13 05 A0 00 93 05 B0 00 90.
  - Expect `we` at addr 0 with 0x00A00513, then addr 1 with 0x00B00593.
  - Expect `core_run`=1 one cycle after 0x90 is accepted, and `words_loaded`=2.
- Bad checksum: the same frame ending in 0x91.
  - Both writes still occur.
  - Then `error`=1, `core_run`=0, `in_ready`=0.
- Empty frame: 00 00 00.
  - No `we`.
  - `core_run`=1 after the 3rd byte.
- Oversize with `ADDR_W`=4: header 11 00 (17 words).
  - `error`=1 one cycle after byte 2.
  - No `we`; subsequent `in_valid` bytes are not accepted.
- Backpressure gaps: the nominal frame with `in_valid` deasserted for 1–3 random cycles between bytes.
  - Identical writes and final state to the nominal load.
- Reset and re-arm:
  - Assert `rst` after 2 payload bytes: no `we`, all outputs at reset values.
  - Replay the nominal frame: it succeeds.
  - Pulse `start` in DONE: `core_run` falls next cycle and HDR0 accepts a new frame.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared state encoding, frame constants and state decodes for the
// boot-time instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_HDR0,
      ST_HDR1,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERROR
   } ld_state_t;

   localparam int unsigned HDR_LEN        = 2;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD);

   // Terminal states stop the byte stream until re-armed.
   function automatic logic accepts_bytes(input ld_state_t s);
      return (s != ST_DONE) && (s != ST_ERROR);
   endfunction

   function automatic logic in_frame(input ld_state_t s);
      return (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; the word is presented
// combinationally together with the pulse for its final byte.
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);
   import imem_loader_pkg::*;

   localparam int unsigned LOW_W = (BYTES_PER_WORD - 1) * 8;

   logic [BIDX_W-1:0] idx_q, idx_d;
   logic [LOW_W-1:0]  sr_q, sr_d;

   // Only the first three bytes are held; the fourth is taken straight from the input.
   always_comb begin
      idx_d = idx_q;
      sr_d  = sr_q;
      if (clr_i) begin
         idx_d = '0;
         sr_d  = '0;
      end else if (byte_valid_i) begin
         idx_d = idx_q + BIDX_W'(1);
         sr_d  = {byte_i, sr_q[LOW_W-1:8]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         sr_q  <= '0;
      end else begin
         idx_q <= idx_d;
         sr_q  <= sr_d;
      end
   end

   assign word_done_o = byte_valid_i & ~clr_i & (idx_q == BIDX_W'(BYTES_PER_WORD - 1));
   assign word_o      = {byte_i, sr_q};

endmodule

// File: rtl/imem_loader.sv
// Frame-driven instruction-memory loader: header, payload words, XOR checksum;
// releases the core only after a fully verified frame.
module imem_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              start,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              core_run,
   output logic              busy,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);
   import imem_loader_pkg::*;

   localparam int unsigned      CNT_W    = HDR_LEN * 8;
   localparam int unsigned      CMP_W    = CNT_W + 1;
   localparam logic [CMP_W-1:0] CAPACITY = CMP_W'(1) << ADDR_W;

   ld_state_t         state_q;
   logic [CNT_W-1:0]  count_q;
   logic [7:0]        xor_q;
   logic [ADDR_W:0]   wcnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;
   logic              run_q;
   logic              err_q;

   logic              accept;
   logic              rearm;
   logic              pk_valid;
   logic              pk_done;
   logic [31:0]       pk_word;
   logic [CNT_W-1:0]  hdr_next;
   logic [ADDR_W:0]   wcnt_next;

   assign in_ready  = accepts_bytes(state_q);
   assign busy      = in_frame(state_q);
   assign accept    = in_valid & in_ready;
   assign rearm     = start & ~in_ready;
   assign pk_valid  = accept & (state_q == ST_DATA);
   // Header bytes shift in from the top so the count ends up little-endian.
   assign hdr_next  = {in_data, count_q[CNT_W-1:8]};
   assign wcnt_next = wcnt_q + (ADDR_W + 1)'(1);

   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (rearm),
      .byte_valid_i (pk_valid),
      .byte_i       (in_data),
      .word_o       (pk_word),
      .word_done_o  (pk_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HDR0;
         count_q <= '0;
         xor_q   <= '0;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            ST_HDR0: begin
               if (accept) begin
                  count_q <= hdr_next;
                  state_q <= ST_HDR1;
               end
            end
            ST_HDR1: begin
               if (accept) begin
                  count_q <= hdr_next;
                  if ({1'b0, hdr_next} > CAPACITY) begin
                     state_q <= ST_ERROR;
                     err_q   <= 1'b1;
                  end else if (hdr_next == '0) begin
                     state_q <= ST_CSUM;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (accept) begin
                  xor_q <= xor_q ^ in_data;
                  if (pk_done) begin
                     we_q    <= 1'b1;
                     waddr_q <= wcnt_q[ADDR_W-1:0];
                     wdata_q <= pk_word;
                     wcnt_q  <= wcnt_next;
                     if (CMP_W'(wcnt_next) == CMP_W'(count_q))
                        state_q <= ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (accept) begin
                  if (in_data == xor_q) begin
                     state_q <= ST_DONE;
                     run_q   <= 1'b1;
                  end else begin
                     state_q <= ST_ERROR;
                     err_q   <= 1'b1;
                  end
               end
            end
            ST_DONE, ST_ERROR: begin
               if (start) begin
                  state_q <= ST_HDR0;
                  run_q   <= 1'b0;
                  err_q   <= 1'b0;
                  xor_q   <= '0;
                  wcnt_q  <= '0;
               end
            end
            default: state_q <= ST_HDR0;
         endcase
      end
   end

   assign we           = we_q;
   assign waddr        = waddr_q;
   assign wdata        = wdata_q;
   assign core_run     = run_q;
   assign error        = err_q;
   assign words_loaded = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle table for the nominal frame,
// plus randomized frames checked against a frame-level reference model.
module tb_imem_loader;

   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = '0;
   logic          start = 1'b0;
   logic          in_ready, we, core_run, busy, error;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic [AW:0]   words_loaded;

   imem_loader #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .start        (start),
      .we           (we),
      .waddr        (waddr),
      .wdata        (wdata),
      .core_run     (core_run),
      .busy         (busy),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      logic          v;
      logic [7:0]    d;
      logic          st;
      logic          rdy;
      logic          we;
      logic          run;
      logic          err;
      logic          bsy;
      logic [AW-1:0] a;
      logic [31:0]   wd;
      logic [AW:0]   wl;
   } vec_t;

   int     checks = 0;
   int     failures = 0;
   wr_t    wlog[$];
   wr_t    exp_w[$];
   bit     exp_ok;
   bit     exp_over;
   int unsigned exp_words;

   always @(negedge clk) begin
      if (we === 1'b1) wlog.push_back('{waddr, wdata});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic st,
                               input logic rdy, input logic w, input logic run,
                               input logic err, input logic bsy, input logic [AW-1:0] a,
                               input logic [31:0] wd, input logic [AW:0] wl);
      vec_t r;
      r = '{v, d, st, rdy, w, run, err, bsy, a, wd, wl};
      return r;
   endfunction

   function automatic bq_t build_frame(input logic [15:0] cnt, input bit good);
      bq_t f;
      logic [7:0] x, b;
      x = '0;
      f.push_back(cnt[7:0]);
      f.push_back(cnt[15:8]);
      if (cnt > 16'(1 << AW)) return f;
      for (int unsigned i = 0; i < 4 * cnt; i++) begin
         b = 8'($urandom);
         x ^= b;
         f.push_back(b);
      end
      f.push_back(good ? x : x ^ 8'($urandom_range(255, 1)));
      return f;
   endfunction

   // Frame-level expectations: writes, outcome and word count.
   task automatic model_frame(input bq_t f);
      int unsigned cnt;
      logic [7:0]  x;
      wr_t         w;
      exp_w.delete();
      cnt = int'({f[1], f[0]});
      exp_over = (cnt > (1 << AW));
      if (exp_over) begin
         exp_ok = 0;
         exp_words = 0;
         return;
      end
      x = '0;
      for (int unsigned i = 0; i < cnt; i++) begin
         w.addr = AW'(i);
         w.data = {f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]};
         exp_w.push_back(w);
         x = x ^ f[2+4*i] ^ f[2+4*i+1] ^ f[2+4*i+2] ^ f[2+4*i+3];
      end
      exp_ok = (f[2+4*cnt] == x);
      exp_words = cnt;
   endtask

   task automatic send(input bq_t f, input int unsigned mingap, input int unsigned maxgap);
      int unsigned gap, waited;
      for (int i = 0; i < f.size(); i++) begin
         gap = (maxgap == 0) ? 0 : $urandom_range(maxgap, mingap);
         repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = f[i];
         waited = 0;
         while (in_ready !== 1'b1 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
         end
         if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_ready_timeout: actual=%0h required=1 byte=%0d", in_ready, i);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input string tag, input bq_t f, input int unsigned mingap,
                            input int unsigned maxgap);
      int unsigned n;
      model_frame(f);
      wlog.delete();
      send(f, mingap, maxgap);
      chk({tag, "_core_run"}, core_run, exp_ok);
      chk({tag, "_error"}, error, !exp_ok);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_words"}, words_loaded, exp_words);
      if (exp_over) begin
         repeat (3) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            chk({tag, "_refuse"}, in_ready, 0);
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
      end
      @(negedge clk); #1;
      chk({tag, "_nwrites"}, wlog.size(), exp_w.size());
      n = (wlog.size() < exp_w.size()) ? wlog.size() : exp_w.size();
      for (int unsigned i = 0; i < n; i++) begin
         chk({tag, "_waddr"}, wlog[i].addr, exp_w[i].addr);
         chk({tag, "_wdata"}, wlog[i].data, exp_w[i].data);
      end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_rearm_run"}, core_run, 0);
      chk({tag, "_rearm_err"}, error, 0);
      chk({tag, "_rearm_rdy"}, in_ready, 1);
      chk({tag, "_rearm_words"}, words_loaded, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_waddr"}, waddr, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_core_run"}, core_run, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_words"}, words_loaded, 0);
   endtask

   vec_t tbl[13];
   bq_t  nominal, frame, partial;

   initial begin
      tbl[0]  = mk(1, 8'h02, 0, 1, 0, 0, 0, 1, '0, '0, 0);
      tbl[1]  = mk(1, 8'h00, 0, 1, 0, 0, 0, 1, '0, '0, 0);
      tbl[2]  = mk(1, 8'h13, 0, 1, 0, 0, 0, 1, '0, '0, 0);
      tbl[3]  = mk(1, 8'h05, 0, 1, 0, 0, 0, 1, '0, '0, 0);
      tbl[4]  = mk(1, 8'hA0, 0, 1, 0, 0, 0, 1, '0, '0, 0);
      tbl[5]  = mk(1, 8'h00, 0, 1, 1, 0, 0, 1, 4'd0, 32'h00A00513, 1);
      tbl[6]  = mk(1, 8'h93, 0, 1, 0, 0, 0, 1, '0, '0, 1);
      tbl[7]  = mk(1, 8'h05, 0, 1, 0, 0, 0, 1, '0, '0, 1);
      tbl[8]  = mk(1, 8'hB0, 0, 1, 0, 0, 0, 1, '0, '0, 1);
      tbl[9]  = mk(1, 8'h00, 0, 1, 1, 0, 0, 1, 4'd1, 32'h00B00593, 2);
      tbl[10] = mk(1, 8'h90, 0, 0, 0, 1, 0, 0, '0, '0, 2);
      tbl[11] = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, '0, '0, 2);
      tbl[12] = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, '0, '0, 0);
      nominal = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00, 8'h90};

      #1;
      chk_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         start    = tbl[i].st;
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_we", i), we, tbl[i].we);
         chk($sformatf("tbl%0d_core_run", i), core_run, tbl[i].run);
         chk($sformatf("tbl%0d_error", i), error, tbl[i].err);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("tbl%0d_words", i), words_loaded, tbl[i].wl);
         if (tbl[i].we) begin
            chk($sformatf("tbl%0d_waddr", i), waddr, tbl[i].a);
            chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].wd);
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;

      run_frame("nominal", nominal, 0, 0);
      run_frame("gaps", nominal, 1, 3);
      frame = nominal;
      frame[10] = 8'h91;
      run_frame("badcsum", frame, 0, 0);
      frame = '{8'h00, 8'h00, 8'h00};
      run_frame("empty", frame, 0, 0);
      run_frame("full", build_frame(16'd16, 1), 0, 1);
      frame = '{8'h11, 8'h00};
      run_frame("oversize", frame, 0, 0);
      frame = '{8'hFF, 8'hFF};
      run_frame("oversize_max", frame, 0, 0);

      for (int k = 0; k < 20; k++) begin
         logic [15:0] cnt;
         cnt = ($urandom_range(9, 0) == 0) ? 16'($urandom_range(40, 17))
                                            : 16'($urandom_range(16, 0));
         run_frame($sformatf("rand%0d", k), build_frame(cnt, $urandom_range(3, 0) != 0), 0, 2);
      end

      partial = '{8'h02, 8'h00, 8'h13, 8'h05};
      wlog.delete();
      send(partial, 0, 0);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      chk("midrst_nwrites", wlog.size(), 0);
      run_frame("replay", nominal, 0, 0);
      run_frame("after_start", build_frame(16'd3, 1), 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
